div_unit: RTL

Multi-cycle integer divider that executes the RV32M DIV, DIVU, REM and REMU operations selected by the control unit's 5-bit ALU opcode. It sits beside the single-cycle ALU in the EX stage. The pipeline starts it with a one-cycle `start` strobe and stalls on `busy`. It returns a registered 32-bit result with a one-cycle `done` pulse.

---
 rtl/div_unit_pkg.sv | 43 ++++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared ALU opcode constants and divider helper types/functions.
package div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 5;
  localparam int unsigned CNT_W = 6;

  // ALU opcodes shared with the control unit
  localparam logic [OPC_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [OPC_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [OPC_W-1:0] ALU_SLL  = 5'b00010;
  localparam logic [OPC_W-1:0] ALU_SLT  = 5'b00011;
  localparam logic [OPC_W-1:0] ALU_SLTU = 5'b00100;
  localparam logic [OPC_W-1:0] ALU_XOR  = 5'b00101;
  localparam logic [OPC_W-1:0] ALU_SRL  = 5'b00110;
  localparam logic [OPC_W-1:0] ALU_SRA  = 5'b00111;
  localparam logic [OPC_W-1:0] ALU_DIV  = 5'b01000;
  localparam logic [OPC_W-1:0] ALU_DIVU = 5'b01001;
  localparam logic [OPC_W-1:0] ALU_REM  = 5'b01010;
  localparam logic [OPC_W-1:0] ALU_REMU = 5'b01011;
  localparam logic [OPC_W-1:0] ALU_OR   = 5'b01100;
  localparam logic [OPC_W-1:0] ALU_AND  = 5'b01101;

  // Per-operation control captured at accept time
  typedef struct packed {
    logic is_rem;
    logic neg_q;
    logic neg_r;
    logic div_zero;
    logic overflow;
  } div_ctl_t;

  // True for DIV, DIVU, REM, REMU
  function automatic logic is_div_op(input logic [OPC_W-1:0] opc);
    return opc[4:2] == 3'b010;
  endfunction

  // Two's-complement magnitude of a signed word
  function automatic logic [XLEN-1:0] abs_word(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;

  // Shift {rem, quo} left and keep the trial subtraction if it does not borrow
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    if (shifted >= {1'b0, divisor}) begin
      rem_out = XLEN'(shifted - {1'b0, divisor});
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU).
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow skip CALC.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [OPC_W-1:0]  alu_opcode,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  state_t            go_state_c;
  logic [CNT_W-1:0]  cnt;
  div_ctl_t          ctl;
  logic [XLEN-1:0]   a_raw;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   step_rem_c;
  logic [XLEN-1:0]   step_quo_c;
  logic [XLEN-1:0]   q_c;
  logic [XLEN-1:0]   r_c;
  logic [XLEN-1:0]   fix_c;
  logic              accept_c;
  logic              load_c;
  logic              signed_c;
  logic              div_zero_c;
  logic              overflow_c;

  div_step u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (divisor),
    .rem_out (step_rem_c),
    .quo_out (step_quo_c)
  );

  // Request decode and first state after accept
  always_comb begin
    signed_c   = ~alu_opcode[0];
    div_zero_c = (operand_b == '0);
    overflow_c = signed_c && (operand_a == 32'h8000_0000) && (operand_b == '1);
`ifdef DIV_FASTPATH_EN
    go_state_c = (div_zero_c || overflow_c) ? S_FIX : S_CALC;
`else
    go_state_c = S_CALC;
`endif
  end

  // Next-state logic; flush overrides any accept
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    accept_c   = start && is_div_op(alu_opcode) &&
                 ((state == S_IDLE) || (state == S_DONE));
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          load_c     = 1'b1;
          state_next = go_state_c;
        end
      end
      S_CALC: begin
        if (cnt == CNT_W'(XLEN - 1)) state_next = S_FIX;
      end
      S_FIX:  state_next = S_DONE;
      S_DONE: begin
        if (accept_c) begin
          load_c     = 1'b1;
          state_next = go_state_c;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      load_c     = 1'b0;
    end
  end

  // Sign correction and special-case override of the final value
  always_comb begin
    q_c = ctl.neg_q ? XLEN'(-quo) : quo;
    r_c = ctl.neg_r ? XLEN'(-rem) : rem;
    if (ctl.div_zero) begin
      q_c = '1;
      r_c = a_raw;
    end else if (ctl.overflow) begin
      q_c = 32'h8000_0000;
      r_c = '0;
    end
    fix_c = ctl.is_rem ? r_c : q_c;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Datapath, iteration counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      ctl     <= '0;
      a_raw   <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      busy <= (state_next == S_CALC) || (state_next == S_FIX);
      done <= (state_next == S_DONE);
      if (load_c) begin
        ctl.is_rem   <= alu_opcode[1];
        ctl.neg_q    <= signed_c && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
        ctl.neg_r    <= signed_c && operand_a[XLEN-1];
        ctl.div_zero <= div_zero_c;
        ctl.overflow <= overflow_c;
        a_raw        <= operand_a;
        divisor      <= signed_c ? abs_word(operand_b) : operand_b;
        quo          <= signed_c ? abs_word(operand_a) : operand_a;
        rem          <= '0;
        cnt          <= '0;
      end else if (flush) begin
        cnt <= '0;
      end else if (state == S_CALC) begin
        rem <= step_rem_c;
        quo <= step_quo_c;
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == S_FIX) && !flush) result <= fix_c;
    end
  end

endmodule
